// File: rtl/sim_boot_ctrl_pkg.sv
// Shared types for the simulation boot controller: FSM states, run results
// and the width used by every counter in the block.
package sim_boot_ctrl_pkg;

   localparam int unsigned CNT_W = 32;

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      RES_NONE    = 2'd0,
      RES_PASS    = 2'd1,
      RES_FAIL    = 2'd2,
      RES_TIMEOUT = 2'd3
   } result_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones
// instead of wrapping. Clear has priority over enable.
module sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         en_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/sim_boot_ctrl.sv
// Simulation boot controller: holds the core in reset, optionally waits for a
// preloaded image, then watches for program exit or a cycle-count timeout.
module sim_boot_ctrl
   import sim_boot_ctrl_pkg::*;
#(
   parameter int unsigned RESET_WAIT_CYCLES = 50,
   parameter bit          PRELOAD           = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             boot_select_i,
   input  logic             execute_from_flash_i,
   input  logic             load_done_i,
   input  logic             exit_valid_i,
   input  logic [31:0]      exit_value_i,
   input  logic [31:0]      max_cycles_i,
   output logic             core_rst_no,
   output logic             boot_select_o,
   output logic             execute_from_flash_o,
   output logic             set_exit_loop_o,
   output logic             done_o,
   output logic [1:0]       result_o,
   output logic [31:0]      exit_code_o,
   output logic [CNT_W-1:0] cycle_cnt_o
);

   localparam logic [CNT_W-1:0] HOLD_LAST =
      (RESET_WAIT_CYCLES > 0) ? CNT_W'(RESET_WAIT_CYCLES - 1) : '0;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] cycle_cnt;
   logic             hold_last;
   logic             active;
   logic             timeout_hit;

   logic             core_rst_n_q, core_rst_n_d;
   logic             boot_select_q, boot_select_d;
   logic             exec_flash_q, exec_flash_d;
   logic             set_exit_loop_q, set_exit_loop_d;
   logic             done_q, done_d;
   result_e          result_q, result_d;
   logic [31:0]      exit_code_q, exit_code_d;

   assign hold_last   = (state_q == ST_HOLD) && (hold_cnt >= HOLD_LAST);
   assign active      = (state_q == ST_LOAD) || (state_q == ST_RUN);
   assign timeout_hit = (max_cycles_i != '0) && (cycle_cnt >= max_cycles_i);

   sat_counter #(.W(CNT_W)) u_hold_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (state_q == ST_HOLD),
      .clr_i  (state_q != ST_HOLD),
      .cnt_o  (hold_cnt)
   );

   // The cycle that moves to DONE does not count, so a timeout freezes at the limit.
   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (active && (state_d != ST_DONE)),
      .clr_i  (state_q == ST_HOLD),
      .cnt_o  (cycle_cnt)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_HOLD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_HOLD: begin
            if (hold_last) begin
               state_d = (PRELOAD && !boot_select_i) ? ST_LOAD : ST_RUN;
            end
         end
         ST_LOAD: begin
            if (exit_valid_i || timeout_hit) begin
               state_d = ST_DONE;
            end else if (load_done_i) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (exit_valid_i || timeout_hit) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_HOLD;
         end
      endcase
   end

   always_comb begin
      core_rst_n_d    = (state_q != ST_HOLD) || hold_last;
      boot_select_d   = boot_select_q;
      exec_flash_d    = exec_flash_q;
      set_exit_loop_d = (state_q == ST_LOAD) && (state_d == ST_RUN);
      done_d          = (state_d == ST_DONE);
      result_d        = result_q;
      exit_code_d     = exit_code_q;

      if (hold_last) begin
         boot_select_d = boot_select_i;
         exec_flash_d  = boot_select_i && execute_from_flash_i;
      end

      // Exit takes priority over a timeout landing in the same cycle.
      if (active) begin
         if (exit_valid_i) begin
            exit_code_d = exit_value_i;
            result_d    = (exit_value_i == '0) ? RES_PASS : RES_FAIL;
         end else if (timeout_hit) begin
            exit_code_d = '0;
            result_d    = RES_TIMEOUT;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         core_rst_n_q    <= 1'b0;
         boot_select_q   <= 1'b0;
         exec_flash_q    <= 1'b0;
         set_exit_loop_q <= 1'b0;
         done_q          <= 1'b0;
         result_q        <= RES_NONE;
         exit_code_q     <= '0;
      end else begin
         core_rst_n_q    <= core_rst_n_d;
         boot_select_q   <= boot_select_d;
         exec_flash_q    <= exec_flash_d;
         set_exit_loop_q <= set_exit_loop_d;
         done_q          <= done_d;
         result_q        <= result_d;
         exit_code_q     <= exit_code_d;
      end
   end

   assign core_rst_no          = core_rst_n_q;
   assign boot_select_o        = boot_select_q;
   assign execute_from_flash_o = exec_flash_q;
   assign set_exit_loop_o      = set_exit_loop_q;
   assign done_o               = done_q;
   assign result_o             = result_q;
   assign exit_code_o          = exit_code_q;
   assign cycle_cnt_o          = cycle_cnt;

endmodule

// File: tb/tb_sim_boot_ctrl.sv
// Directed bench for sim_boot_ctrl: boot paths, timeout, exit/timeout race,
// reset mid-run and strap stability, with end-of-run results scoreboarded.
module tb_sim_boot_ctrl;
   import sim_boot_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        boot_sel;
   logic        exe_flash;
   logic        load_done;
   logic        exit_valid;
   logic [31:0] exit_value;
   logic [31:0] max_cycles;
   logic        core_rst_n;
   logic        boot_sel_o;
   logic        exe_flash_o;
   logic        set_exit_loop;
   logic        done;
   logic [1:0]  result;
   logic [31:0] exit_code;
   logic [31:0] cycle_cnt;

   int total = 0;
   int bad   = 0;
   int pulses = 0;
   int p0;

   typedef struct {
      string       tag;
      logic [1:0]  res;
      logic [31:0] code;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   sim_boot_ctrl #(.RESET_WAIT_CYCLES(50), .PRELOAD(1'b1)) dut (
      .clk_i                (clk),
      .rst_ni               (rst_n),
      .boot_select_i        (boot_sel),
      .execute_from_flash_i (exe_flash),
      .load_done_i          (load_done),
      .exit_valid_i         (exit_valid),
      .exit_value_i         (exit_value),
      .max_cycles_i         (max_cycles),
      .core_rst_no          (core_rst_n),
      .boot_select_o        (boot_sel_o),
      .execute_from_flash_o (exe_flash_o),
      .set_exit_loop_o      (set_exit_loop),
      .done_o               (done),
      .result_o             (result),
      .exit_code_o          (exit_code),
      .cycle_cnt_o          (cycle_cnt)
   );

   // Counts release pulses one edge late, so readers must wait a cycle.
   always @(posedge clk) if (set_exit_loop === 1'b1) pulses++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_end(input string tag, input logic [1:0] res, input logic [31:0] code);
      exp_t e;
      e.tag  = tag;
      e.res  = res;
      e.code = code;
      sb_q.push_back(e);
   endtask

   task automatic wait_end();
      exp_t e;
      int   n = 0;
      while (done !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      e = sb_q.pop_front();
      check({e.tag, "_done"}, 32'(done), 32'd1);
      check({e.tag, "_result"}, 32'(result), 32'(e.res));
      check({e.tag, "_code"}, exit_code, e.code);
      $display("run %s: done=%0b result=%0d code=%0d cycles=%0d",
               e.tag, done, result, exit_code, cycle_cnt);
   endtask

   task automatic do_reset(input int ncyc, input logic bs, input logic ef, input logic [31:0] maxc);
      rst_n      = 1'b0;
      boot_sel   = bs;
      exe_flash  = ef;
      max_cycles = maxc;
      load_done  = 1'b0;
      exit_valid = 1'b0;
      exit_value = '0;
      repeat (ncyc) @(negedge clk);
      check("rst_core_rst", 32'(core_rst_n), 32'd0);
      check("rst_boot_sel", 32'(boot_sel_o), 32'd0);
      check("rst_exe_flash", 32'(exe_flash_o), 32'd0);
      check("rst_exit_loop", 32'(set_exit_loop), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'(RES_NONE));
      check("rst_code", exit_code, 32'd0);
      check("rst_cycles", cycle_cnt, 32'd0);
      rst_n = 1'b1;
   endtask

   // core reset must stay low through cycle 49 and be high in cycle 50
   task automatic check_hold(input string tag);
      repeat (49) @(negedge clk);
      check({tag, "_hold_low"}, 32'(core_rst_n), 32'd0);
      @(negedge clk);
      check({tag, "_hold_rise"}, 32'(core_rst_n), 32'd1);
      $display("boot %s: core reset released, boot_sel=%0b exe_flash=%0b",
               tag, boot_sel_o, exe_flash_o);
   endtask

   initial begin
      // preload path, flash strap must be masked when boot_select=0
      do_reset(2, 1'b0, 1'b1, 32'd0);
      check_hold("boot0");
      check("boot0_sel", 32'(boot_sel_o), 32'd0);
      check("boot0_flash_masked", 32'(exe_flash_o), 32'd0);
      p0 = pulses;
      repeat (10) @(negedge clk);
      load_done = 1'b1;
      @(negedge clk);
      check("boot0_pulse_hi", 32'(set_exit_loop), 32'd1);
      check("boot0_cycles_at_load", cycle_cnt, 32'd11);
      @(negedge clk);
      check("boot0_pulse_lo", 32'(set_exit_loop), 32'd0);
      load_done = 1'b0;
      expect_end("boot0_pass", RES_PASS, 32'd0);
      exit_value = 32'd0;
      exit_valid = 1'b1;
      @(negedge clk);
      exit_valid = 1'b0;
      wait_end();
      exit_value = 32'd5;
      exit_valid = 1'b1;
      repeat (3) @(negedge clk);
      exit_valid = 1'b0;
      check("done_absorb_result", 32'(result), 32'(RES_PASS));
      check("done_absorb_code", exit_code, 32'd0);
      check("done_absorb_done", 32'(done), 32'd1);
      check("done_absorb_core_rst", 32'(core_rst_n), 32'd1);
      check("boot0_pulse_count", 32'(pulses - p0), 32'd1);

      // flash path, then strap toggling after HOLD
      do_reset(2, 1'b1, 1'b1, 32'd0);
      check_hold("flash");
      check("flash_sel", 32'(boot_sel_o), 32'd1);
      check("flash_exe", 32'(exe_flash_o), 32'd1);
      p0 = pulses;
      boot_sel  = 1'b0;
      exe_flash = 1'b0;
      repeat (5) @(negedge clk);
      check("strap_stable_sel", 32'(boot_sel_o), 32'd1);
      check("strap_stable_exe", 32'(exe_flash_o), 32'd1);
      expect_end("flash_fail7", RES_FAIL, 32'd7);
      exit_value = 32'd7;
      exit_valid = 1'b1;
      @(negedge clk);
      exit_valid = 1'b0;
      wait_end();
      repeat (2) @(negedge clk);
      check("flash_no_pulse", 32'(pulses - p0), 32'd0);

      // timeout with no exit
      do_reset(2, 1'b1, 1'b0, 32'd100);
      check_hold("timeout");
      expect_end("timeout", RES_TIMEOUT, 32'd0);
      wait_end();
      check("timeout_cycles", cycle_cnt, 32'd100);
      repeat (5) @(negedge clk);
      check("timeout_cycles_frozen", cycle_cnt, 32'd100);

      // exit arriving on the very cycle the timeout fires
      do_reset(2, 1'b1, 1'b0, 32'd100);
      check_hold("simul");
      repeat (100) @(negedge clk);
      check("simul_cycles", cycle_cnt, 32'd100);
      expect_end("simul_exit_wins", RES_PASS, 32'd0);
      exit_value = 32'd0;
      exit_valid = 1'b1;
      @(negedge clk);
      exit_valid = 1'b0;
      wait_end();

      // reset mid-RUN at cycle 200 with new straps
      do_reset(2, 1'b1, 1'b1, 32'd0);
      check_hold("midrun");
      repeat (150) @(negedge clk);
      check("midrun_running", 32'(done), 32'd0);
      do_reset(1, 1'b0, 1'b1, 32'd0);
      check_hold("rerun");
      check("rerun_sel", 32'(boot_sel_o), 32'd0);
      check("rerun_exe", 32'(exe_flash_o), 32'd0);

      // load_done and exit together in LOAD: exit taken, no release pulse
      repeat (3) @(negedge clk);
      p0 = pulses;
      expect_end("load_exit_race", RES_FAIL, 32'd3);
      load_done  = 1'b1;
      exit_valid = 1'b1;
      exit_value = 32'd3;
      @(negedge clk);
      load_done  = 1'b0;
      exit_valid = 1'b0;
      wait_end();
      repeat (2) @(negedge clk);
      check("race_no_pulse", 32'(pulses - p0), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sim_boot_ctrl.md
SIM_BOOT_CTRL -- requirements
Module: sim_boot_ctrl

Interface
REQ-001 The block SHALL have the parameter RESET_WAIT_CYCLES, default 50, setting the number of clk_i cycles that core reset is held after block reset.
REQ-002 The block SHALL have the parameter PRELOAD, default 1; when 1, boot_select_i=0 runs the LOAD phase; when 0, LOAD is skipped.
REQ-003 The block SHALL have the port clk_i, input, 1 bit: the single clock.
REQ-004 The block SHALL have the port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have the port boot_select_i, input, 1 bit: boot strap (0 jtag/preload, 1 flash).
REQ-006 The block SHALL have the port execute_from_flash_i, input, 1 bit: SPI strap, used only when boot_select_i=1.
REQ-007 The block SHALL have the port load_done_i, input, 1 bit: level, high when the memory image is written.
REQ-008 The block SHALL have the port exit_valid_i, input, 1 bit: the program signals termination.
REQ-009 The block SHALL have the port exit_value_i, input, 32 bits: the program exit code.
REQ-010 The block SHALL have the port max_cycles_i, input, 32 bits: timeout limit; 0 disables the timeout.
REQ-011 The block SHALL have the port core_rst_no, output, 1 bit: active-low reset to the system under control.
REQ-012 The block SHALL have the port boot_select_o, output, 1 bit: latched strap.
REQ-013 The block SHALL have the port execute_from_flash_o, output, 1 bit: latched strap, forced 0 when boot_select_o=0.
REQ-014 The block SHALL have the port set_exit_loop_o, output, 1 bit: 1-cycle pulse releasing the core from its boot loop.
REQ-015 The block SHALL have the port done_o, output, 1 bit: sticky, high when the run has finished.
REQ-016 The block SHALL have the port result_o, output, 2 bits: 0 NONE, 1 PASS, 2 FAIL, 3 TIMEOUT.
REQ-017 The block SHALL have the port exit_code_o, output, 32 bits: captured exit_value_i.
REQ-018 The block SHALL have the port cycle_cnt_o, output, 32 bits: cycles since core reset release, saturating.

Function
REQ-019 The FSM SHALL have the states HOLD, LOAD, RUN and DONE; any cycle with rst_ni=0 SHALL enter HOLD.
REQ-020 HOLD SHALL drive core_rst_no=0 and count hold_cnt from 0; when hold_cnt = RESET_WAIT_CYCLES-1, the next cycle SHALL set core_rst_no=1.
REQ-021 The straps SHALL be latched on the last HOLD cycle and held constant until the next rst_ni assertion.
REQ-022 The exit from HOLD SHALL go to LOAD if PRELOAD=1 and boot_select_i=0, and to RUN otherwise.
REQ-023 LOAD SHALL wait for load_done_i=1; in the same cycle set_exit_loop_o SHALL be 1 for exactly one cycle, and the next state SHALL be RUN.
REQ-024 cycle_cnt_o SHALL increment every cycle in LOAD and RUN, saturate at 2^32-1, and freeze in DONE.
REQ-025 In LOAD or RUN, exit_valid_i=1 SHALL cause a move to DONE, capture exit_code_o, and set result_o to PASS if exit_value_i=0 and to FAIL otherwise.
REQ-026 In LOAD or RUN, with max_cycles_i≠0 and cycle_cnt_o ≥ max_cycles_i, the block SHALL move to DONE with result_o=TIMEOUT and exit_code_o=0.
REQ-027 If exit_valid_i and the timeout condition occur in the same cycle, exit SHALL win.
REQ-028 If load_done_i and exit_valid_i occur in the same cycle in LOAD, the exit SHALL be taken and set_exit_loop_o SHALL not pulse.
REQ-029 DONE SHALL be absorbing: done_o=1, core_rst_no stays 1, and later exit_valid_i is ignored.
REQ-030 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-031 While rst_ni=0 at a clk_i edge, the block SHALL set: state HOLD, hold_cnt 0, core_rst_no 0, boot_select_o 0, execute_from_flash_o 0, set_exit_loop_o 0, done_o 0, result_o NONE, exit_code_o 0, cycle_cnt_o 0.
REQ-032 Reset asserted mid-LOAD, mid-RUN or in DONE SHALL restart the full HOLD sequence and re-latch the straps.

Structure
REQ-033 The package sim_boot_ctrl_pkg SHALL hold the state enum, the result_e enum (NONE/PASS/FAIL/TIMEOUT) and the 32-bit counter width constant.
REQ-034 The block SHALL use one sub-module, sat_counter (enable, clear, saturating), for both hold_cnt and cycle_cnt.

Verification
REQ-035 Boot 0 path: boot_select_i=0, RESET_WAIT_CYCLES=50 -> core_rst_no rises on cycle 50; load_done_i at cycle 60 -> one set_exit_loop_o pulse; exit_valid_i with value 0 -> done_o=1 and result_o=PASS.
REQ-036 Flash path: boot_select_i=1, execute_from_flash_i=1 -> LOAD skipped, no set_exit_loop_o pulse, execute_from_flash_o=1; exit value 7 -> FAIL with exit_code_o=7.
REQ-037 Timeout: max_cycles_i=100 with no exit -> result_o=TIMEOUT and cycle_cnt_o frozen at 100.
REQ-038 Simultaneous events: exit_valid_i with value 0 on the same cycle the timeout hits -> PASS.
REQ-039 Reset mid-RUN: rst_ni low for 1 cycle at cycle 200 -> all outputs at reset values, core_rst_no low for 50 more cycles, straps re-latched.
REQ-040 Strap stability: toggling boot_select_i after HOLD -> boot_select_o unchanged.
